// File: rtl/cache_nway_control.sv
// N-way set-associative cache controller FSM: services CPU hits, and handles misses with
// write-back/allocate (or write-through), a latched victim, and a bounded memory retry budget.
module cache_nway_control #(
    parameter int WAYS         = 4,
    parameter int WRITE_POLICY = 0,
    parameter int MAX_RETRY    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cpu_cyc,
    input  logic            cpu_stb,
    input  logic            cpu_we,
    output logic            cpu_ack,
    output logic            cpu_err,
    input  logic            hit,
    input  logic [WAYS-1:0] hit_way,
    input  logic [WAYS-1:0] victim_way,
    input  logic            victim_dirty,
    output logic [WAYS-1:0] way_write,
    output logic [WAYS-1:0] valid_write,
    output logic            valid_in,
    output logic [WAYS-1:0] dirty_write,
    output logic            dirty_in,
    output logic            lru_update,
    output logic [WAYS-1:0] lru_way,
    output logic            datainmux_sel,
    output logic            memaddrmux_sel,
    output logic            load_mar,
    output logic            load_mdr,
    output logic            mem_cyc,
    output logic            mem_stb,
    output logic            mem_we,
    input  logic            mem_ack,
    input  logic            mem_rty
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE_BACK,
        WB_GAP,
        ALLOCATE,
        WT_WRITE,
        FAIL
    } state_t;

    state_t          state, state_next;
    logic [WAYS-1:0] victim_q;
    logic [RW-1:0]   retry_cnt;
    logic            req;
    logic            mem_phase;
    logic            latch_victim;
    logic            retry_inc;
    logic            retry_clr;

    assign req = cpu_cyc & cpu_stb;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            victim_q  <= '0;
            retry_cnt <= '0;
        end else begin
            state <= state_next;
            if (latch_victim) victim_q <= victim_way;
            if (retry_clr) retry_cnt <= '0;
            else if (retry_inc) retry_cnt <= retry_cnt + 1'b1;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next     = state;
        cpu_ack        = 1'b0;
        cpu_err        = 1'b0;
        way_write      = '0;
        valid_write    = '0;
        valid_in       = 1'b0;
        dirty_write    = '0;
        dirty_in       = 1'b0;
        lru_update     = 1'b0;
        lru_way        = '0;
        datainmux_sel  = 1'b0;
        memaddrmux_sel = 1'b0;
        load_mar       = 1'b0;
        load_mdr       = 1'b0;
        mem_cyc        = 1'b0;
        mem_stb        = 1'b0;
        mem_we         = 1'b0;
        mem_phase      = 1'b0;
        latch_victim   = 1'b0;
        retry_inc      = 1'b0;
        retry_clr      = 1'b0;

        // The IDLE hit outputs are Mealy, so gating on rst_n keeps every output low during reset.
        if (rst_n) begin
            unique case (state)
                IDLE: begin
                    if (req && hit) begin
                        lru_update = 1'b1;
                        lru_way    = hit_way;
                        if (!cpu_we) begin
                            cpu_ack = 1'b1;
                        end else if (WRITE_POLICY == 0) begin
                            cpu_ack       = 1'b1;
                            datainmux_sel = 1'b1;
                            way_write     = hit_way;
                            valid_write   = hit_way;
                            dirty_write   = hit_way;
                            valid_in      = 1'b1;
                            dirty_in      = 1'b1;
                        end else begin
                            datainmux_sel = 1'b1;
                            way_write     = hit_way;
                            state_next    = WT_WRITE;
                        end
                    end else if (req) begin
                        latch_victim = 1'b1;
                        state_next   = (victim_dirty && WRITE_POLICY == 0) ? WRITE_BACK : ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    mem_phase      = 1'b1;
                    mem_cyc        = 1'b1;
                    mem_stb        = 1'b1;
                    mem_we         = 1'b1;
                    memaddrmux_sel = 1'b1;
                    load_mar       = 1'b1;
                    load_mdr       = 1'b1;
                    if (mem_ack) state_next = WB_GAP;
                end
                WB_GAP: begin
                    retry_clr  = 1'b1;
                    state_next = ALLOCATE;
                end
                ALLOCATE: begin
                    mem_phase   = 1'b1;
                    mem_cyc     = 1'b1;
                    mem_stb     = 1'b1;
                    load_mar    = 1'b1;
                    way_write   = victim_q;
                    valid_write = victim_q;
                    dirty_write = victim_q;
                    valid_in    = 1'b1;
                    if (mem_ack) state_next = IDLE;
                end
                WT_WRITE: begin
                    mem_phase = 1'b1;
                    mem_cyc   = 1'b1;
                    mem_stb   = 1'b1;
                    mem_we    = 1'b1;
                    load_mar  = 1'b1;
                    load_mdr  = 1'b1;
                    if (mem_ack) begin
                        cpu_ack    = 1'b1;
                        state_next = IDLE;
                    end
                end
                FAIL: begin
                    cpu_err    = 1'b1;
                    retry_clr  = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase

            // Ack beats retry; the last tolerated retry beat aborts the miss through FAIL.
            if (mem_phase) begin
                if (mem_ack) begin
                    retry_clr = 1'b1;
                end else if (mem_rty) begin
                    if (retry_cnt == RW'(MAX_RETRY - 1)) state_next = FAIL;
                    else retry_inc = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_nway_control.sv
// Randomized bench: a write-back (MAX_RETRY=3) and a write-through (MAX_RETRY=4) controller
// share one stimulus stream and are compared each cycle against a transaction-level model.
module tb_cache_nway_control;

    localparam int WAYS = 4;
    localparam int NDUT = 2;
    localparam int CYCLES = 5000;

    // Model phases of a CPU request, independent of any RTL encoding.
    localparam int PH_IDLE = 0, PH_EVICT = 1, PH_PAUSE = 2, PH_FILL = 3, PH_THRU = 4, PH_ERR = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic cpu_cyc, cpu_stb, cpu_we, hit, victim_dirty, mem_ack, mem_rty;
    logic [WAYS-1:0] hit_way, victim_way;

    logic [NDUT-1:0]           cpu_ack, cpu_err, valid_in, dirty_in, lru_update;
    logic [NDUT-1:0]           datainmux_sel, memaddrmux_sel, load_mar, load_mdr;
    logic [NDUT-1:0]           mem_cyc, mem_stb, mem_we;
    logic [NDUT-1:0][WAYS-1:0] way_write, valid_write, dirty_write, lru_way;

    int tests_run = 0;
    int tests_failed = 0;

    int              policy [NDUT] = '{0, 1};
    int              max_rty[NDUT] = '{3, 4};
    int              phase  [NDUT];
    int              tries  [NDUT];
    logic [WAYS-1:0] vic    [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        cache_nway_control #(
            .WAYS(WAYS),
            .WRITE_POLICY(g),
            .MAX_RETRY(3 + g)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .cpu_cyc(cpu_cyc),
            .cpu_stb(cpu_stb),
            .cpu_we(cpu_we),
            .cpu_ack(cpu_ack[g]),
            .cpu_err(cpu_err[g]),
            .hit(hit),
            .hit_way(hit_way),
            .victim_way(victim_way),
            .victim_dirty(victim_dirty),
            .way_write(way_write[g]),
            .valid_write(valid_write[g]),
            .valid_in(valid_in[g]),
            .dirty_write(dirty_write[g]),
            .dirty_in(dirty_in[g]),
            .lru_update(lru_update[g]),
            .lru_way(lru_way[g]),
            .datainmux_sel(datainmux_sel[g]),
            .memaddrmux_sel(memaddrmux_sel[g]),
            .load_mar(load_mar[g]),
            .load_mdr(load_mdr[g]),
            .mem_cyc(mem_cyc[g]),
            .mem_stb(mem_stb[g]),
            .mem_we(mem_we[g]),
            .mem_ack(mem_ack),
            .mem_rty(mem_rty)
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output bundle: {ack,err,way_write,valid_write,valid_in,dirty_write,dirty_in,lru_update,
    //                 lru_way,datainmux,memaddrmux,mar,mdr,mem_cyc,mem_stb,mem_we}
    function automatic logic [27:0] observed(int g);
        return {cpu_ack[g], cpu_err[g], way_write[g], valid_write[g], valid_in[g],
                dirty_write[g], dirty_in[g], lru_update[g], lru_way[g], datainmux_sel[g],
                memaddrmux_sel[g], load_mar[g], load_mdr[g], mem_cyc[g], mem_stb[g], mem_we[g]};
    endfunction

    function automatic logic [27:0] expected(int g);
        logic ack = 0, err = 0, vin = 0, din = 0, lru = 0, dmux = 0, amux = 0;
        logic mar = 0, mdr = 0, cyc = 0, stb = 0, we = 0;
        logic [WAYS-1:0] ww = '0, vw = '0, dw = '0, lw = '0;
        if (rst_n) begin
            case (phase[g])
                PH_IDLE: if (cpu_cyc && cpu_stb && hit) begin
                    lru = 1; lw = hit_way;
                    if (!cpu_we) ack = 1;
                    else if (policy[g] == 0) begin
                        ack = 1; dmux = 1; ww = hit_way; vw = hit_way; dw = hit_way; vin = 1; din = 1;
                    end else begin
                        dmux = 1; ww = hit_way;
                    end
                end
                PH_EVICT: begin cyc = 1; stb = 1; we = 1; amux = 1; mar = 1; mdr = 1; end
                PH_FILL:  begin cyc = 1; stb = 1; mar = 1; ww = vic[g]; vw = vic[g]; dw = vic[g]; vin = 1; end
                PH_THRU:  begin cyc = 1; stb = 1; we = 1; mar = 1; mdr = 1; ack = mem_ack; end
                PH_ERR:   err = 1;
                default: ;
            endcase
        end
        return {ack, err, ww, vw, vin, dw, din, lru, lw, dmux, amux, mar, mdr, cyc, stb, we};
    endfunction

    task automatic model_step(int g);
        int nxt;
        if (!rst_n) begin
            phase[g] = PH_IDLE; tries[g] = 0; vic[g] = '0;
            return;
        end
        nxt = phase[g];
        case (phase[g])
            PH_IDLE: if (cpu_cyc && cpu_stb) begin
                if (hit) begin
                    if (cpu_we && policy[g] == 1) nxt = PH_THRU;
                end else begin
                    vic[g] = victim_way;
                    nxt = (victim_dirty && policy[g] == 0) ? PH_EVICT : PH_FILL;
                end
            end
            PH_PAUSE: begin tries[g] = 0; nxt = PH_FILL; end
            PH_ERR:   begin tries[g] = 0; nxt = PH_IDLE; end
            default: begin
                if (mem_ack) begin
                    tries[g] = 0;
                    nxt = (phase[g] == PH_EVICT) ? PH_PAUSE : PH_IDLE;
                end else if (mem_rty) begin
                    if (tries[g] == max_rty[g] - 1) nxt = PH_ERR;
                    else tries[g]++;
                end
            end
        endcase
        phase[g] = nxt;
    endtask

    initial begin
        bit in_reset = 1'b0;
        rst_n = 1'b0;
        {cpu_cyc, cpu_stb, cpu_we, hit, victim_dirty, mem_ack, mem_rty} = '0;
        hit_way = '0;
        victim_way = '0;
        for (int g = 0; g < NDUT; g++) begin
            phase[g] = PH_IDLE; tries[g] = 0; vic[g] = '0;
        end

        // Reset holds every output low even with a read hit presented.
        repeat (2) @(negedge clk);
        {cpu_cyc, cpu_stb, hit} = 3'b111;
        hit_way = 4'b0100;
        #1;
        for (int g = 0; g < NDUT; g++) check($sformatf("reset_dut%0d", g), 64'(observed(g)), 64'(0));

        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            if (cyc != 0) begin
                @(posedge clk);
                #1;
            end
            if (in_reset) begin
                rst_n = 1'b1;
                in_reset = 1'b0;
            end
            cpu_cyc      = ($urandom_range(9) < 8);
            cpu_stb      = ($urandom_range(9) < 8);
            cpu_we       = $urandom_range(1);
            hit          = $urandom_range(1);
            hit_way      = WAYS'(1 << $urandom_range(WAYS - 1));
            victim_way   = WAYS'(1 << $urandom_range(WAYS - 1));
            victim_dirty = $urandom_range(1);
            mem_ack      = ($urandom_range(99) < 35);
            mem_rty      = ($urandom_range(99) < 45);
            if ($urandom_range(149) == 0) begin
                rst_n = 1'b0;
                in_reset = 1'b1;
            end
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                check($sformatf("cyc%0d_dut%0d_ph%0d", cyc, g, phase[g]),
                      64'(observed(g)), 64'(expected(g)));
                model_step(g);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
